// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: stream source / memory sink; slave: the loader itself
    modport master (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: 16-bit big-endian word count, then big-endian words into imem
// Optional opcode screening of each written word is built when OPCODE_CHECK_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic          err_opcode
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE} state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state, state_nx;
    logic [15:0]       count;
    logic [15:0]       wcnt;
    logic [15:0]       wcnt_inc;
    logic [15:0]       hdr_count;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              ready_c;
    logic              we_c;
    logic              xfer;
    logic              in_range;

    assign ready_c   = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign xfer      = ready_c & bus.byte_valid;
    assign wcnt_inc  = wcnt + 16'd1;
    assign hdr_count = {count[15:8], bus.byte_data};
    assign in_range  = ({1'b0, wcnt} < DEPTH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        we_c     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = HDR0;
            HDR0:  if (xfer) state_nx = HDR1;
            HDR1:  if (xfer) state_nx = (hdr_count == 16'd0) ? DONE : DATA;
            DATA:  if (xfer && byte_idx == 2'd3) state_nx = WRITE;
            WRITE: begin
                we_c     = in_range;
                state_nx = (wcnt_inc == count) ? DONE : DATA;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            wcnt         <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wcnt         <= '0;
                    byte_idx     <= '0;
                    err_overflow <= 1'b0;
                end
                HDR0: if (xfer) count[15:8] <= bus.byte_data;
                HDR1: if (xfer) begin
                    count[7:0] <= bus.byte_data;
                    if ({1'b0, hdr_count} > DEPTH_L) err_overflow <= 1'b1;
                end
                DATA: if (xfer) begin
                    if (byte_idx == 2'd3) begin
                        // Latch the finished word and its address so they hold outside WRITE.
                        wdata_q  <= {shift, bus.byte_data};
                        addr_q   <= wcnt[ADDR_W-1:0];
                        byte_idx <= '0;
                    end else begin
                        shift    <= {shift[15:0], bus.byte_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE:   wcnt <= wcnt_inc;
                default: ;
            endcase
        end
    end

`ifdef OPCODE_CHECK_EN
    logic err_opcode_q;
    logic op_ok;

    always_comb begin
        op_ok = 1'b0;
        case (wdata_q[31:26])
            6'b000000, 6'b110000, 6'b001000, 6'b001100,
            6'b100011, 6'b101011, 6'b000100, 6'b000010: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             err_opcode_q <= 1'b0;
        else if (state == IDLE && start)       err_opcode_q <= 1'b0;
        else if (state == WRITE && !op_ok)     err_opcode_q <= 1'b1;
    end

    assign err_opcode = err_opcode_q;
`else
    assign err_opcode = 1'b0;
`endif

    assign busy           = (state != IDLE);
    assign cpu_hold       = busy;
    assign done           = (state == DONE);
    assign bus.byte_ready = ready_c;
    assign bus.imem_we    = we_c;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed and random loads
module tb_imem_loader;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err_overflow, err_opcode;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_opcode(err_opcode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    typedef struct { int a; logic [31:0] d; int c; } wr_t;
    typedef struct { int c; bit ov; bit op; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    int  rel_cyc = -10;

    logic [5:0] ok_ops [8] = '{6'b000000, 6'b110000, 6'b001000, 6'b001100,
                               6'b100011, 6'b101011, 6'b000100, 6'b000010};

    function automatic bit supported(logic [5:0] op);
        foreach (ok_ops[i]) if (ok_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_word();
        if ($urandom_range(0, 1) == 1) return {ok_ops[$urandom_range(0, 7)], 26'($urandom)};
        return $urandom;
    endfunction

    // Monitor: every write and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin : mon
        wr_t e;
        dn_t d;
        if (!reset) begin
            if (bus.imem_we) begin
                chk("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
                if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
                else begin
                    e = wq.pop_front();
                    chk("write_addr", 64'(bus.imem_addr), 64'(e.a));
                    chk("write_data", 64'(bus.imem_wdata), 64'(e.d));
                    chk("write_cycle", 64'(cyc), 64'(e.c));
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    d = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d.c));
                    chk("err_overflow", 64'(err_overflow), 64'(d.ov));
                    chk("err_opcode", 64'(err_opcode), 64'(d.op));
                    chk("hold_at_done", 64'({cpu_hold, busy}), 64'd3);
                end
                rel_cyc = cyc + 1;
            end
            if (cyc == rel_cyc) chk("core_release", 64'({cpu_hold, busy}), 64'd0);
        end
    end

    int gap_mode = 0;
    bit alt = 1'b0;
    logic [31:0] wl[$];

    task automatic send_byte(input logic [7:0] b, output int hs);
        int n;
        n = 0;
        hs = -1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n > 200) begin
                chk("byte_accept_timeout", 64'd1, 64'd0);
                return;
            end
            alt = ~alt;
            if ((gap_mode == 1 && alt) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.byte_valid = 1'b0;
                continue;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            if (bus.byte_ready) begin
                hs = cyc + 1;
                return;
            end
        end
    endtask

    task automatic do_load(input int cnt, input bit mid_start);
        int hs;
        bit eov, eop;
        logic [15:0] c16;
        c16 = 16'(cnt);
        @(negedge clk);
        start = 1'b1;
        bus.byte_valid = 1'b0;
        eov = (cnt > DEPTH);
        eop = 1'b0;
        send_byte(c16[15:8], hs);
        if (mid_start) start = 1'b1;
        send_byte(c16[7:0], hs);
        if (hs < 0) return;
        if (cnt == 0) dq.push_back('{hs, eov, 1'b0});
        for (int i = 0; i < cnt; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(wl[i][31-8*j -: 8], hs);
                if (hs < 0) return;
            end
`ifdef OPCODE_CHECK_EN
            if (!supported(wl[i][31:26])) eop = 1'b1;
`endif
            if (i < DEPTH) wq.push_back('{i, wl[i], hs});
        end
        if (cnt > 0) dq.push_back('{hs + 1, eov, eop});
        @(negedge clk);
        bus.byte_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (!busy && dq.size() == 0 && wq.size() == 0) break;
            @(negedge clk);
        end
        chk("load_complete", 64'({busy, dq.size() != 0, wq.size() != 0}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs;
        int cnt;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                                  cpu_hold, busy, done, err_overflow, err_opcode}), 64'd0);
        reset = 1'b0;

        gap_mode = 0;
        wl = '{32'h20010005, 32'h08000000};
        do_load(2, 1'b0);

        gap_mode = 1;
        do_load(2, 1'b0);

        // Abort mid-load: header 0x0002 and two data bytes, then async reset.
        gap_mode = 0;
        @(negedge clk);
        start = 1'b1;
        send_byte(8'h00, hs);
        send_byte(8'h02, hs);
        send_byte(8'hAB, hs);
        send_byte(8'hCD, hs);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midload_reset_async", 64'({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                                        cpu_hold, busy, done, err_overflow, err_opcode}), 64'd0);
        @(negedge clk);
        chk("midload_reset_held", 64'({bus.byte_ready, cpu_hold, busy, done}), 64'd0);
        reset = 1'b0;
        wl = '{32'h8C220004};
        do_load(1, 1'b0);

        do_load(0, 1'b1);

        wl = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        do_load(DEPTH + 1, 1'b0);

        wl = '{32'hFC000000};
        do_load(1, 1'b0);
        wl = '{32'h10220003};
        do_load(1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            cnt = $urandom_range(0, DEPTH + 3);
            gap_mode = $urandom_range(0, 2);
            wl = {};
            for (int i = 0; i < cnt; i++) wl.push_back(rand_word());
            do_load(cnt, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("queues_drained", 64'(wq.size() + dq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
